// File: rtl/bcd_pkg.sv
// Shared definitions for the binary-to-BCD converter and future display-scan blocks.
// Holds the controller state encoding, the digit width and a digit-count sanity helper.
package bcd_pkg;

   localparam int unsigned DigitW = 4;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StShift = 2'd1,
      StDone  = 2'd2
   } state_e;

   // Decimal digits of 2**w - 1 equal floor(w * log10(2)) + 1 for w >= 1.
   function automatic bit digits_fit(int unsigned w, int unsigned d);
      longint unsigned need;
      need = (64'(w) * 64'd301029996) / 64'd1000000000 + 64'd1;
      return 64'(d) >= need;
   endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Request/result bundle between a binary source and the BCD converter.
// The master side issues start/bin; the slave side returns busy/done/bcd/en.
interface bin2bcd_seq_if #(
   parameter int unsigned W = 16,
   parameter int unsigned D = 5
);
   import bcd_pkg::*;

   logic                  start;
   logic [W-1:0]          bin;
   logic                  busy;
   logic                  done;
   logic [DigitW*D-1:0]   bcd;
   logic [D-1:0]          en;

   modport master (
      output start, bin,
      input  busy, done, bcd, en
   );

   modport slave (
      input  start, bin,
      output busy, done, bcd, en
   );

endinterface

// File: rtl/bcd_adj3.sv
// Double-dabble digit correction: add 3 to a BCD nibble that is 5 or more.
// The add is 4-bit and never carries out for legal digit values.
module bcd_adj3
   import bcd_pkg::*;
(
   input  logic [DigitW-1:0] nib,
   output logic [DigitW-1:0] adj
);

   always_comb begin
      adj = nib;
      if (nib >= 4'd5) begin
         adj = nib + 4'd3;
      end
   end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per cycle, with
// registered packed digits and leading-zero blanking enables for the segment decoders.
module bin2bcd_seq
   import bcd_pkg::*;
#(
   parameter int unsigned W = 16,
   parameter int unsigned D = 5
) (
   input  logic          clk,
   input  logic          rst,
   bin2bcd_seq_if.slave  bus
);

   localparam int unsigned BcdW  = DigitW * D;
   localparam int unsigned WorkW = BcdW + W;
   localparam int unsigned CntW  = $clog2(W + 1);

   if (W < 1 || !digits_fit(W, D)) begin : g_param_check
      $error("bin2bcd_seq: W must be >= 1 and 10**D must exceed 2**W - 1");
   end

   state_e              state_q;
   logic [CntW-1:0]     cnt_q;
   logic [WorkW-1:0]    work_q;
   logic [WorkW-1:0]    work_shift;
   logic [BcdW-1:0]     adj;
   logic [BcdW-1:0]     bcd_q;
   logic [D-1:0]        en_q;
   logic [D-1:0]        en_next;
   logic                busy_q;
   logic                done_q;
   logic                any_nz;

   for (genvar k = 0; k < D; k++) begin : g_adj
      bcd_adj3 u_adj (
         .nib (work_q[W + DigitW*k +: DigitW]),
         .adj (adj[DigitW*k +: DigitW])
      );
   end

   // One double-dabble iteration: correct every digit, then shift the whole register.
   always_comb begin
      work_shift = {adj, work_q[W-1:0]} << 1;
   end

   // Digit k is shown when it or any more significant digit is nonzero.
   always_comb begin
      en_next    = '0;
      en_next[0] = 1'b1;
      any_nz     = 1'b0;
      for (int k = int'(D) - 1; k >= 1; k--) begin
         any_nz     = any_nz | (work_shift[W + DigitW*k +: DigitW] != '0);
         en_next[k] = any_nz;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         work_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         bcd_q   <= '0;
         en_q    <= D'(1);
      end else begin
         done_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (bus.start) begin
                  work_q  <= {{BcdW{1'b0}}, bus.bin};
                  cnt_q   <= CntW'(W);
                  busy_q  <= 1'b1;
                  state_q <= StShift;
               end
            end
            StShift: begin
               work_q <= work_shift;
               cnt_q  <= cnt_q - CntW'(1);
               if (cnt_q == CntW'(1)) begin
                  state_q <= StDone;
                  done_q  <= 1'b1;
                  bcd_q   <= work_shift[WorkW-1 -: BcdW];
                  en_q    <= en_next;
               end
            end
            StDone: begin
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.bcd  = bcd_q;
   assign bus.en   = en_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: cycle-accurate behavioural model compared every cycle,
// plus directed conversions with hand-computed digit and blanking expectations.
module tb_bin2bcd_seq;

   localparam int unsigned W   = 16;
   localparam int unsigned D   = 5;
   localparam int          Lat = int'(W) + 1;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int n_checks  = 0;
   int n_pass    = 0;
   int done_seen = 0;

   bin2bcd_seq_if #(.W(W), .D(D)) bus ();

   bin2bcd_seq #(.W(W), .D(D)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Model: cycles since accept (0 = idle), latched operand and last shown result.
   int          phase = 0;
   logic [15:0] pend  = '0;
   logic [19:0] m_bcd = '0;
   logic [4:0]  m_en  = 5'b00001;
   bit          chk_en = 1'b0;

   function automatic logic [19:0] to_bcd(int unsigned v);
      logic [19:0] r;
      r = '0;
      for (int k = 0; k < 5; k++) begin
         r[4*k +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   // Digit k is lit when the value has more than k decimal digits.
   function automatic logic [4:0] blank(int unsigned v);
      logic [4:0]  e;
      int unsigned p;
      e = 5'b00001;
      p = 10;
      for (int k = 1; k < 5; k++) begin
         if (v >= p) e[k] = 1'b1;
         p = p * 10;
      end
      return e;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   initial forever begin
      @(posedge clk);
      if (rst) begin
         phase = 0;
         m_bcd = '0;
         m_en  = 5'b00001;
      end else if (phase == 0) begin
         if (bus.start) begin
            phase = 1;
            pend  = bus.bin;
         end
      end else if (phase == Lat) begin
         phase = 0;
      end else begin
         phase++;
         if (phase == Lat) begin
            m_bcd = to_bcd(int'(pend));
            m_en  = blank(int'(pend));
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         if (bus.done === 1'b1) done_seen++;
         check("cycle {busy,done,bcd,en}",
               {bus.busy, bus.done, bus.bcd, bus.en},
               {phase != 0, phase == Lat, m_bcd, m_en});
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
      $fatal(1, "watchdog expired");
   end

   // Called at a negedge while the DUT is idle; returns at the negedge after done.
   task automatic conv(input int unsigned v, input logic [19:0] exp_bcd,
                       input logic [4:0] exp_en, input string tag);
      int n;
      bit seen;
      bus.start = 1'b1;
      bus.bin   = 16'(v);
      n    = 0;
      seen = 1'b0;
      while (!seen && n < 40) begin
         @(negedge clk);
         n++;
         bus.start = 1'b0;
         bus.bin   = 16'($urandom);
         if (bus.done === 1'b1) seen = 1'b1;
      end
      check({tag, " latency"}, 64'(n), 64'(Lat));
      check({tag, " bcd"}, 64'(bus.bcd), 64'(exp_bcd));
      check({tag, " en"}, 64'(bus.en), 64'(exp_en));
      @(negedge clk);
   endtask

   initial begin
      int n;
      int dones;
      bit seen;
      logic [19:0] got_bcd;

      bus.start = 1'b0;
      bus.bin   = '0;
      repeat (3) @(negedge clk);
      chk_en = 1'b1;
      rst    = 1'b0;

      check("reset bcd", 64'(bus.bcd), 64'h0);
      check("reset en", 64'(bus.en), 64'b00001);
      check("reset busy", 64'(bus.busy), 64'h0);
      check("reset done", 64'(bus.done), 64'h0);
      repeat (20) @(negedge clk);
      check("idle no done", 64'(done_seen), 64'h0);

      conv(0, 20'h00000, 5'b00001, "zero");
      conv(65535, 20'h65535, 5'b11111, "max");
      conv(1009, 20'h01009, 5'b01111, "1009");
      conv(7, 20'h00007, 5'b00001, "seven");

      // Start requests while busy or in the done cycle are dropped.
      bus.start = 1'b1;
      bus.bin   = 16'd1234;
      dones   = 0;
      got_bcd = '0;
      for (n = 1; n <= 30; n++) begin
         @(negedge clk);
         if (bus.done === 1'b1) begin
            dones++;
            got_bcd = bus.bcd;
         end
         bus.start = (n == 5 || n == 17);
         bus.bin   = (n == 5 || n == 17) ? 16'd9999 : 16'($urandom);
      end
      check("ignore done count", 64'(dones), 64'd1);
      check("ignore bcd", 64'(got_bcd), 64'h01234);
      conv(9999, 20'h09999, 5'b01111, "after ignore");

      // Reset mid-conversion aborts without a done pulse.
      bus.start = 1'b1;
      bus.bin   = 16'd4321;
      dones = 0;
      for (n = 1; n <= 30; n++) begin
         @(negedge clk);
         if (bus.done === 1'b1) dones++;
         bus.start = 1'b0;
         rst       = (n == 8);
      end
      check("abort done count", 64'(dones), 64'd0);
      check("abort bcd", 64'(bus.bcd), 64'h0);
      check("abort en", 64'(bus.en), 64'b00001);
      check("abort busy", 64'(bus.busy), 64'h0);
      conv(42, 20'h00042, 5'b00011, "42");

      // Continuous start: one result every W+2 cycles, operand alternating.
      bus.start = 1'b1;
      bus.bin   = 16'd100;
      n = 0;
      for (int r = 0; r < 6; r++) begin
         seen = 1'b0;
         while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (bus.done === 1'b1) seen = 1'b1;
         end
         check("stream period", 64'(n), (r == 0) ? 64'(Lat) : 64'(Lat + 1));
         check("stream bcd", 64'(bus.bcd), (r % 2 == 1) ? 64'h50000 : 64'h00100);
         check("stream en", 64'(bus.en), (r % 2 == 1) ? 64'b11111 : 64'b00111);
         @(negedge clk);
         n = 1;
         bus.bin = ((r + 1) % 2 == 1) ? 16'd50000 : 16'd100;
      end
      bus.start = 1'b0;
      repeat (3) @(negedge clk);

      // Random traffic: sporadic starts, operand noise and occasional resets.
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         rst       = ($urandom_range(0, 149) == 0);
         bus.start = ($urandom_range(0, 2) == 0);
         case ($urandom_range(0, 5))
            0:       bus.bin = 16'd0;
            1:       bus.bin = 16'hffff;
            2:       bus.bin = 16'($urandom_range(0, 99));
            3:       bus.bin = 16'($urandom_range(9990, 10010));
            default: bus.bin = 16'($urandom);
         endcase
      end
      rst       = 1'b0;
      bus.start = 1'b0;
      repeat (25) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
